// File: rtl/carregador_matriz_4x4.sv
// Collects a row-major stream of 16 signed elements, packs them into the 4x4 matrix bus
// and holds the frame under a valid/ready handshake; malformed frames are dropped.
module carregador_matriz_4x4 #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [ELEM_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [16*ELEM_W-1:0]   matriz_4x4,
  output logic                   mat_valid,
  input  logic                   mat_ready,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int unsigned BusW = 16 * ELEM_W;

  typedef enum logic [1:0] {StFill, StHold, StFlush} state_e;

  state_e             state_q, state_d;
  logic [3:0]         elem_cnt_q, elem_cnt_d;
  // The 16th element goes straight from in_data to the bus, so only 15 slots are stored.
  logic [ELEM_W-1:0]  shadow_q [15];
  logic [ELEM_W-1:0]  shadow_d [15];
  logic [BusW-1:0]    mat_q, mat_d;
  logic               mat_valid_q, mat_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BusW-1:0]    frame_packed;
  logic               accept;

  assign in_ready = !clear && (state_q != StHold);
  assign accept   = in_valid && in_ready;

  always_comb begin
    frame_packed = '0;
    for (int k = 0; k < 15; k++) begin
      frame_packed[BusW-1-ELEM_W*k -: ELEM_W] = shadow_q[k];
    end
    frame_packed[ELEM_W-1:0] = in_data;
  end

  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    shadow_d    = shadow_q;
    mat_d       = mat_q;
    mat_valid_d = mat_valid_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (clear) begin
      elem_cnt_d  = '0;
      mat_valid_d = 1'b0;
      state_d     = StFill;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (elem_cnt_q == 4'd15) begin
              elem_cnt_d = '0;
              if (in_last) begin
                mat_d       = frame_packed;
                mat_valid_d = 1'b1;
                state_d     = StHold;
              end else begin
                frame_err_d = 1'b1;
                state_d     = StFlush;
              end
            end else begin
              shadow_d[elem_cnt_q] = in_data;
              if (in_last) begin
                frame_err_d = 1'b1;
                elem_cnt_d  = '0;
              end else begin
                elem_cnt_d = elem_cnt_q + 4'd1;
              end
            end
          end
        end
        StHold: begin
          if (mat_valid_q && mat_ready) begin
            mat_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = StFill;
          end
        end
        StFlush: begin
          if (accept && in_last) begin
            state_d = StFill;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      elem_cnt_q  <= '0;
      for (int k = 0; k < 15; k++) begin
        shadow_q[k] <= '0;
      end
      mat_q       <= '0;
      mat_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      shadow_q    <= shadow_d;
      mat_q       <= mat_d;
      mat_valid_q <= mat_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign matriz_4x4 = mat_q;
  assign mat_valid  = mat_valid_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_carregador_matriz_4x4.sv
// Directed stimulus for carregador_matriz_4x4; expected frames are queued at issue time
// and a negedge monitor pops and compares them on every handoff.
module tb_carregador_matriz_4x4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         mat_ready = 1'b0;
  logic         in_ready, mat_valid, frame_err;
  logic [127:0] matriz;
  logic [15:0]  frame_cnt;
  logic         in_ready2, mat_valid2, frame_err2;
  logic [127:0] matriz2;
  logic [1:0]   frame_cnt2;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [127:0] exp_q[$];

  carregador_matriz_4x4 #(.ELEM_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .matriz_4x4(matriz), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  carregador_matriz_4x4 #(.ELEM_W(8), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .matriz_4x4(matriz2), .mat_valid(mat_valid2),
    .mat_ready(mat_ready), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_err) err_seen++;
    if (rst_n && mat_valid && mat_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff: unexpected frame %h, none expected", matriz);
      end else begin
        chk("handoff", matriz, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered #1 after a posedge; returns #1 after the edge that accepted the element.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] m, input bit push);
    if (push) exp_q.push_back(m);
    for (int k = 0; k < 16; k++) begin
      send(m[127-8*k -: 8], k == 15);
    end
  endtask

  localparam logic [127:0] F1  = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] FID = 128'h01000000000100000000010000000001;
  localparam logic [127:0] FFF = {128{1'b1}};
  localparam logic [127:0] F4  = 128'h807F01FF00112233445566778899AABB;
  localparam logic [127:0] F5  = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] FH  = 128'hDEADBEEFCAFEF00D1234567890ABCDEF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [127:0] fr;

    #3;
    chk("reset_matriz", matriz, '0);
    chk("reset_valid_err", {mat_valid, frame_err}, 2'b00);
    chk("reset_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(1);
    chk("reset_in_ready", in_ready, 1);

    // Frame 1..16, downstream ready
    mat_ready = 1'b1;
    send_frame(F1, 1);
    chk("t1_valid_after_last", mat_valid, 1);
    chk("t1_in_ready_hold", in_ready, 0);
    wait_cycles(1);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_valid_dropped", mat_valid, 0);

    // Identity frame held for 10 cycles
    mat_ready = 1'b0;
    send_frame(FID, 1);
    repeat (10) begin
      @(negedge clk);
      chk("t2_hold_bus", matriz, FID);
      chk("t2_hold_ctl", {in_ready, mat_valid}, 2'b01);
    end
    @(posedge clk);
    #1;
    mat_ready = 1'b1;
    wait_cycles(1);
    chk("t2_after_handoff", {in_ready, mat_valid}, 2'b10);
    chk("t2_frame_cnt", frame_cnt, 2);

    // Early in_last on 5th element, then all -1
    e0 = err_seen;
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    wait_cycles(2);
    chk("t3_err_once", err_seen - e0, 1);
    chk("t3_no_valid", mat_valid, 0);
    send_frame(FFF, 1);
    wait_cycles(2);
    chk("t3_frame_cnt", frame_cnt, 3);
    chk("t3_bus_retained", matriz, FFF);

    // Missing in_last: 20 elements
    e0 = err_seen;
    for (int i = 1; i <= 20; i++) send(8'(i), i == 20);
    wait_cycles(2);
    chk("t4_err_once", err_seen - e0, 1);
    chk("t4_no_valid", mat_valid, 0);
    send_frame(F4, 1);
    wait_cycles(2);
    chk("t4_frame_cnt", frame_cnt, 4);

    // Clear mid-frame, then 16..1
    e0 = err_seen;
    for (int i = 1; i <= 7; i++) send(8'(i + 32), 1'b0);
    clear = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_clear", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    send_frame(F5, 1);
    wait_cycles(2);
    chk("t5_bus", matriz, F5);
    chk("t5_no_err", err_seen - e0, 0);
    chk("t5_frame_cnt", frame_cnt, 5);

    // Clear during HOLD
    mat_ready = 1'b0;
    send_frame(FH, 0);
    chk("t5_hold_valid", mat_valid, 1);
    clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0;
    chk("t5_clear_valid", mat_valid, 0);
    chk("t5_clear_cnt", frame_cnt, 5);
    chk("t5_clear_bus", matriz, FH);
    mat_ready = 1'b1;
    wait_cycles(2);
    chk("t5_clear_ctl", {in_ready, mat_valid}, 2'b10);

    // Async reset mid-frame, off the clock edge
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bus", matriz, '0);
    chk("t6_rst_ctl", {mat_valid, frame_err}, 2'b00);
    chk("t6_rst_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(1);
    for (int f = 0; f < 5; f++) begin
      fr = {16{8'(f + 1)}};
      send_frame(fr, 1);
    end
    wait_cycles(2);
    chk("t6_cnt16", frame_cnt, 5);
    chk("t6_cnt2_wrap", frame_cnt2, 1);

    wait_cycles(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
